// File: rtl/nbit_adder_pkg.sv
// Shared definitions for the chunked add/subtract unit: FSM state codes,
// saturation limits and the operand/chunk width compatibility check.
package nbit_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Largest positive two's-complement value of an n-bit word (n <= 64).
    function automatic logic [63:0] sat_pos(input int unsigned n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of an n-bit word (n <= 64).
    function automatic logic [63:0] sat_neg(input int unsigned n);
        return 64'd1 << (n - 1);
    endfunction

    function automatic bit chunk_fits(input int unsigned n, input int unsigned chunk);
        return (chunk != 0) && (n % chunk == 0);
    endfunction

endpackage

// File: rtl/nbit_chunked_addsub_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry full adder, shared by every RUN cycle
// of the chunked add/subtract unit.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    always_comb begin
        logic [CHUNK:0] c;
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        cout = c[CHUNK];
    end

endmodule

// File: rtl/nbit_chunked_addsub.sv
// Multi-cycle N-bit add/subtract/accumulate unit, CHUNK bits per clock with a
// start/busy/done handshake. Define ADDER_SAT_EN to saturate on overflow.
module nbit_chunked_addsub
    import nbit_adder_pkg::*;
#(
    parameter int N     = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic         acc_en,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] out,
    output logic         c_out,
    output logic         ovf,
    output logic         busy,
    output logic         done
);

    localparam int K     = N / CHUNK;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(K - 1);

    if (!chunk_fits(N, CHUNK)) begin : g_bad_chunk
        $error("nbit_chunked_addsub: N must be a multiple of CHUNK");
    end

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic [N-1:0]     shadow;
    logic [N-1:0]     sum_next;
    logic [N-1:0]     result_next;
    logic             ovf_next;
    logic [N-1:0]     out_r;
    logic             c_out_r;
    logic             ovf_r;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_cout;
    logic             accept;

`ifdef ADDER_SAT_EN
    function automatic logic [N-1:0] saturate(input logic [N-1:0] sum,
                                              input logic a_msb,
                                              input logic of);
        if (!of)
            return sum;
        return a_msb ? N'(sat_neg(N)) : N'(sat_pos(N));
    endfunction
`endif

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .x    (op_a[idx*CHUNK +: CHUNK]),
        .y    (op_b[idx*CHUNK +: CHUNK]),
        .cin  (carry),
        .s    (chunk_s),
        .cout (chunk_cout)
    );

    assign accept = start && (state != RUN);

    // The final chunk is merged combinationally so DONE sees the complete sum.
    always_comb begin
        sum_next                      = shadow;
        sum_next[idx*CHUNK +: CHUNK]  = chunk_s;
        ovf_next = (op_a[N-1] == op_b[N-1]) && (sum_next[N-1] != op_a[N-1]);
`ifdef ADDER_SAT_EN
        result_next = saturate(sum_next, op_a[N-1], ovf_next);
`else
        result_next = sum_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            out_r   <= '0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (state == RUN) begin
            carry <= chunk_cout;
            if (idx == LAST) begin
                state   <= DONE;
                idx     <= '0;
                out_r   <= result_next;
                c_out_r <= chunk_cout;
                ovf_r   <= ovf_next;
            end else begin
                idx <= idx + 1'b1;
            end
        end else if (accept) begin
            state <= RUN;
            idx   <= '0;
            carry <= sub ? 1'b1 : c_in;
        end else begin
            state <= IDLE;
        end
    end

    // Operand and partial-sum storage: no reset, control gates every use.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a <= acc_en ? out_r : a;
            op_b <= sub ? ~b : b;
        end
        if (state == RUN)
            shadow <= sum_next;
    end

    assign out   = out_r;
    assign c_out = c_out_r;
    assign ovf   = ovf_r;
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_nbit_chunked_addsub.sv
// Directed bench for nbit_chunked_addsub with a whole-word arithmetic model
// compared every cycle, plus literal expectations for each directed vector.
module tb_nbit_chunked_addsub;

    localparam int N     = 16;
    localparam int CHUNK = 4;
    localparam int K     = N / CHUNK;

    logic          clk = 1'b0;
    logic          rst, start, sub, acc_en, c_in;
    logic [N-1:0]  a, b;
    logic [N-1:0]  out;
    logic          c_out, ovf, busy, done;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    nbit_chunked_addsub #(.N(N), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .acc_en(acc_en),
        .a(a), .b(b), .c_in(c_in), .out(out), .c_out(c_out), .ovf(ovf),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-word model: result computed at acceptance, revealed K edges later.
    logic [N-1:0] m_out, p_out, opa, opb, msum;
    logic [N:0]   full;
    logic         m_c, m_ovf, m_done, p_c, p_ovf, accepted, ci;
    int           m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_out = '0; m_c = 1'b0; m_ovf = 1'b0; m_done = 1'b0; m_cnt = 0;
        end else begin
            accepted = start && (m_cnt == 0);
            m_done   = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_out = p_out; m_c = p_c; m_ovf = p_ovf; m_done = 1'b1;
                end
            end
            if (accepted) begin
                opa   = acc_en ? m_out : a;
                opb   = sub ? ~b : b;
                ci    = sub ? 1'b1 : c_in;
                full  = {1'b0, opa} + {1'b0, opb} + {{N{1'b0}}, ci};
                msum  = full[N-1:0];
                p_c   = full[N];
                p_ovf = (opa[N-1] == opb[N-1]) && (msum[N-1] != opa[N-1]);
                p_out = msum;
`ifdef ADDER_SAT_EN
                if (p_ovf) p_out = opa[N-1] ? 16'h8000 : 16'h7FFF;
`endif
                m_cnt = K;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",  32'(busy),  32'(m_cnt > 0));
            check("done",  32'(done),  32'(m_done));
            check("out",   32'(out),   32'(m_out));
            check("c_out", 32'(c_out), 32'(m_c));
            check("ovf",   32'(ovf),   32'(m_ovf));
        end
    end

    task automatic run(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic ts,
                       input logic tacc, input logic tc);
        @(negedge clk);
        a = ta; b = tb_; sub = ts; acc_en = tacc; c_in = tc; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns at the negedge inside the DONE cycle; nb counts busy cycles seen.
    task automatic wait_done(input string name, output int nb);
        bit seen;
        seen = 1'b0;
        nb   = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) nb++;
        end
        if (!seen) begin
            n_vec++; n_miss++;
            $display("FAIL %s_timeout: got no done, expected done within 20 cycles", name);
        end
    endtask

    task automatic expect_res(input string name, input logic [N-1:0] eo, input logic ec,
                              input logic eov);
        check({name, "_out"},   32'(out),   32'(eo));
        check({name, "_c_out"}, 32'(c_out), 32'(ec));
        check({name, "_ovf"},   32'(ovf),   32'(eov));
    endtask

    task automatic count_done(input string name, input int cycles);
        int nd;
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check(name, 32'(nd), 32'd0);
    endtask

    initial begin
        int nb;
        logic [N-1:0] exp_sat;
        rst = 1'b1; start = 1'b0; sub = 1'b0; acc_en = 1'b0; c_in = 1'b0;
        a = '0; b = '0;
        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        repeat (10) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        expect_res("idle", 16'h0000, 1'b0, 1'b0);

        run(16'h000B, 16'h0007, 1'b0, 1'b0, 1'b0);
        wait_done("add1", nb);
        check("add1_busy_cycles", 32'(nb), 32'(K));
        expect_res("add1", 16'h0012, 1'b0, 1'b0);

        // Accumulate started in the DONE cycle, then a start pulse while busy.
        a = 16'hFFFF; b = 16'h0003; sub = 1'b0; acc_en = 1'b1; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; acc_en = 1'b0;
        @(posedge clk);
        #1 a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("acc", nb);
        expect_res("acc", 16'h0015, 1'b0, 1'b0);
        count_done("acc_extra_done", 8);
        expect_res("acc_hold", 16'h0015, 1'b0, 1'b0);

        run(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        wait_done("wrap", nb);
        expect_res("wrap", 16'h0000, 1'b1, 1'b0);

`ifdef ADDER_SAT_EN
        exp_sat = 16'h7FFF;
`else
        exp_sat = 16'h8000;
`endif
        run(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        wait_done("ovf", nb);
        expect_res("ovf", exp_sat, 1'b0, 1'b1);

        run(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1);
        wait_done("cin", nb);
        expect_res("cin", 16'h0008, 1'b0, 1'b0);

        run(16'h0007, 16'h0005, 1'b1, 1'b0, 1'b0);
        wait_done("sub_pos", nb);
        expect_res("sub_pos", 16'h0002, 1'b1, 1'b0);

        run(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b1);
        wait_done("sub_neg", nb);
        expect_res("sub_neg", 16'hFFFE, 1'b0, 1'b0);

        // Abort: start at edge t, rst sampled at edge t+2.
        run(16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        expect_res("abort", 16'h0000, 1'b0, 1'b0);
        count_done("abort_no_done", 6);

        run(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
        wait_done("post_rst", nb);
        check("post_rst_busy_cycles", 32'(nb), 32'(K));
        expect_res("post_rst", 16'h2345, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
